collision_arbiter: RTL and testbench

//  Parametrised next-generation collision unit for the VGA game datapath.
//  - Takes one drawingRequest bit per drawable object.
//  - Builds every enabled object pair, registered.
//  - Emits a one-shot pulse per pair per frame and latches per-frame hit summaries.
//  - Applies a frame-counted lockout (invulnerability window) after "lethal" pairs.
//  - Sits between the object drawers and the game-state logic (score, lives, shields).

---
 rtl/collision_arbiter_if.sv | 30 +++
 rtl/collision_arbiter.sv | 121 ++++++++++++
 tb/tb_collision_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_arbiter_if.sv
// collision_arbiter_if: pixel-side inputs and collision/frame-summary outputs of collision_arbiter.
// Latency: none, signal bundle only.
// Backpressure: none, every signal is a plain level or single-cycle pulse.
interface collision_arbiter_if #(
  parameter int N_OBJ = 6,
  parameter int CNT_W = 8
);
  localparam int N_PAIR = N_OBJ * (N_OBJ - 1) / 2;

  logic              startOfFrame;
  logic              enable;
  logic [N_OBJ-1:0]  drawingRequest;
  logic [N_PAIR-1:0] collision_level;
  logic [N_PAIR-1:0] collision_pulse;
  logic [N_PAIR-1:0] frame_hits;
  logic [CNT_W-1:0]  hit_count;
  logic              locked;
  logic [7:0]        lockout_left;

  // Drawer/frame-timing side drives the pixel flags; game-state side consumes the results.
  modport master (
    output startOfFrame, enable, drawingRequest,
    input  collision_level, collision_pulse, frame_hits, hit_count, locked, lockout_left
  );

  modport slave (
    input  startOfFrame, enable, drawingRequest,
    output collision_level, collision_pulse, frame_hits, hit_count, locked, lockout_left
  );
endinterface

// File: rtl/collision_arbiter.sv
// collision_arbiter: pairwise object-overlap detector with per-frame one-shot pulses, hit summaries and lockout.
// Latency: one cycle from drawingRequest/startOfFrame/enable to every output.
// Backpressure: none; one pixel is consumed every clock and all outputs are registered levels or pulses.
module collision_arbiter #(
  parameter int                             N_OBJ          = 6,
  parameter logic [N_OBJ*(N_OBJ-1)/2-1:0]   PAIR_MASK      = '1,
  parameter logic [N_OBJ*(N_OBJ-1)/2-1:0]   LOCK_MASK      = '0,
  parameter int                             LOCKOUT_FRAMES = 60,
  parameter int                             CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  collision_arbiter_if.slave bus
);
  localparam int          N_PAIR   = N_OBJ * (N_OBJ - 1) / 2;
  localparam logic [31:0] CNT_MAX  = (32'd1 << CNT_W) - 32'd1;
  localparam logic [7:0]  LOCK_LEN = 8'(LOCKOUT_FRAMES);
  localparam bit          LOCK_EN  = (LOCKOUT_FRAMES > 0);

  typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_LOCKOUT} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_lock_left, w_lock_left_nxt;
  logic [N_PAIR-1:0] w_raw, w_eligible, w_pulse;
  logic [N_PAIR-1:0] r_level, r_pulse, r_frame_hits, r_cur_hits;
  logic [CNT_W-1:0]  r_hit_count, r_cur_count, w_cnt_nxt;
  logic [31:0]       w_cnt_sum;

  // Pair k walks (0,1),(0,2)..(0,N-1),(1,2)..; the closed form below gives k for (i,j).
  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_i
    for (genvar gj = gi + 1; gj < N_OBJ; gj++) begin : g_j
      localparam int K = gi * N_OBJ - gi * (gi + 1) / 2 + (gj - gi - 1);
      assign w_raw[K] = bus.drawingRequest[gi] & bus.drawingRequest[gj] & PAIR_MASK[K];
    end
  end

  // Qualify pulses by state and first-hit-this-frame, then pick the next state and lockout count.
  always_comb begin
    w_state_nxt     = r_state;
    w_lock_left_nxt = r_lock_left;
    case (r_state)
      S_ARMED:   w_eligible = '1;
      S_LOCKOUT: w_eligible = ~LOCK_MASK;
      default:   w_eligible = '0;
    endcase
    // A hit on the frame-start edge belongs to the new frame, so old hits must not mask it.
    w_pulse = w_raw & w_eligible & (bus.startOfFrame ? {N_PAIR{1'b1}} : ~r_cur_hits);
    if (!bus.enable) begin
      w_state_nxt     = S_DISARMED;
      w_lock_left_nxt = 8'd0;
    end else begin
      case (r_state)
        S_DISARMED: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (LOCK_EN && (|(w_pulse & LOCK_MASK))) begin
            w_state_nxt     = S_LOCKOUT;
            w_lock_left_nxt = LOCK_LEN;
          end
        end
        S_LOCKOUT: begin
          if (bus.startOfFrame) begin
            if (r_lock_left <= 8'd1) begin
              w_state_nxt     = S_ARMED;
              w_lock_left_nxt = 8'd0;
            end else begin
              w_lock_left_nxt = r_lock_left - 8'd1;
            end
          end
        end
        default: w_state_nxt = S_DISARMED;
      endcase
    end
  end

  // Saturating pulse count; a frame boundary restarts the sum from this cycle's pulses.
  always_comb begin
    w_cnt_sum = (bus.startOfFrame ? 32'd0 : 32'(r_cur_count)) + 32'($countones(w_pulse));
    w_cnt_nxt = (w_cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_cnt_sum);
  end

  // State register and lockout frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_DISARMED;
      r_lock_left <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_left <= w_lock_left_nxt;
    end
  end

  // Registered level/pulse outputs plus current-frame accumulation and frame-boundary snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level      <= '0;
      r_pulse      <= '0;
      r_frame_hits <= '0;
      r_hit_count  <= '0;
      r_cur_hits   <= '0;
      r_cur_count  <= '0;
    end else begin
      r_level     <= w_raw;
      r_pulse     <= w_pulse;
      r_cur_count <= w_cnt_nxt;
      if (bus.startOfFrame) begin
        r_frame_hits <= r_cur_hits;
        r_hit_count  <= r_cur_count;
        r_cur_hits   <= w_pulse;
      end else begin
        r_cur_hits   <= r_cur_hits | w_pulse;
      end
    end
  end

  assign bus.collision_level = r_level;
  assign bus.collision_pulse = r_pulse;
  assign bus.frame_hits      = r_frame_hits;
  assign bus.hit_count       = r_hit_count;
  assign bus.locked          = (r_state == S_LOCKOUT);
  assign bus.lockout_left    = r_lock_left;
endmodule

// File: tb/tb_collision_arbiter.sv
// tb_collision_arbiter: directed and random stimulus on two differently parametrised collision_arbiter instances.
// Latency: outputs compared one cycle after the edge that sampled the stimulus, at edge+1ns.
// Backpressure: none; a new stimulus vector every clock.
module tb_collision_arbiter;
  localparam int NO = 6;
  localparam int NP = 15;
  // Unit 0: pair (4,5) masked, no lockout, 8-bit counter.
  localparam logic [NP-1:0] PM0 = 15'h3FFF;
  localparam logic [NP-1:0] LM0 = 15'h0000;
  // Unit 1: pair (0,3) masked, pair (0,1) lethal, 3-frame lockout, 2-bit counter.
  localparam logic [NP-1:0] PM1 = 15'h7FFB;
  localparam logic [NP-1:0] LM1 = 15'h0001;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          sof   = 1'b0;
  logic          en    = 1'b0;
  logic [NO-1:0] dr    = '0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  collision_arbiter_if #(.N_OBJ(NO), .CNT_W(8)) if0 ();
  collision_arbiter_if #(.N_OBJ(NO), .CNT_W(2)) if1 ();

  assign if0.startOfFrame   = sof;
  assign if0.enable         = en;
  assign if0.drawingRequest = dr;
  assign if1.startOfFrame   = sof;
  assign if1.enable         = en;
  assign if1.drawingRequest = dr;

  collision_arbiter #(.N_OBJ(NO), .PAIR_MASK(PM0), .LOCK_MASK(LM0), .LOCKOUT_FRAMES(60), .CNT_W(8))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  collision_arbiter #(.N_OBJ(NO), .PAIR_MASK(PM1), .LOCK_MASK(LM1), .LOCKOUT_FRAMES(3), .CNT_W(2))
    u1 (.clk(clk), .reset(reset), .bus(if1));

  // Reference model: pair list, per-unit configuration, armed flag + remaining lockout frames.
  int            pi_a [NP];
  int            pj_a [NP];
  logic [NP-1:0] pm [2];
  logic [NP-1:0] lm [2];
  int            lf [2];
  int            cmax [2];
  bit            m_armed [2];
  int            m_left [2];
  logic [NP-1:0] m_cur [2];
  int            m_cnt [2];
  logic [NP-1:0] e_level [2];
  logic [NP-1:0] e_pulse [2];
  logic [NP-1:0] e_fh [2];
  int            e_hc [2];
  int            e_left [2];
  bit            e_locked [2];

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_armed[u] = 0; m_left[u] = 0; m_cur[u] = '0; m_cnt[u] = 0;
      e_level[u] = '0; e_pulse[u] = '0; e_fh[u] = '0; e_hc[u] = 0;
      e_left[u] = 0; e_locked[u] = 0;
    end
  endfunction

  function automatic void model_step(int u, bit s, bit e, logic [NO-1:0] d);
    logic [NP-1:0] raw;
    logic [NP-1:0] pul;
    int n;
    raw = '0; pul = '0; n = 0;
    for (int k = 0; k < NP; k++) begin
      raw[k] = d[pi_a[k]] & d[pj_a[k]] & pm[u][k];
      if (m_armed[u] && raw[k] && (s || !m_cur[u][k]) && !(m_left[u] > 0 && lm[u][k])) begin
        pul[k] = 1'b1;
        n++;
      end
    end
    e_level[u] = raw;
    e_pulse[u] = pul;
    if (s) begin
      e_fh[u]  = m_cur[u];
      e_hc[u]  = m_cnt[u];
      m_cur[u] = pul;
      m_cnt[u] = (n > cmax[u]) ? cmax[u] : n;
    end else begin
      m_cur[u] = m_cur[u] | pul;
      m_cnt[u] = (m_cnt[u] + n > cmax[u]) ? cmax[u] : m_cnt[u] + n;
    end
    if (!e) begin
      m_armed[u] = 0;
      m_left[u]  = 0;
    end else if (!m_armed[u]) begin
      m_armed[u] = 1;
    end else if (m_left[u] > 0) begin
      if (s) m_left[u] = m_left[u] - 1;
    end else if (lf[u] > 0 && (pul & lm[u]) != '0) begin
      m_left[u] = lf[u];
    end
    e_locked[u] = (m_left[u] > 0);
    e_left[u]   = m_left[u];
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_unit(input int u, input logic [31:0] lv, input logic [31:0] pu,
                            input logic [31:0] fh, input logic [31:0] hc,
                            input logic [31:0] lk, input logic [31:0] ll);
    chk($sformatf("u%0d.level", u),        lv, 32'(e_level[u]));
    chk($sformatf("u%0d.pulse", u),        pu, 32'(e_pulse[u]));
    chk($sformatf("u%0d.frame_hits", u),   fh, 32'(e_fh[u]));
    chk($sformatf("u%0d.hit_count", u),    hc, 32'(e_hc[u]));
    chk($sformatf("u%0d.locked", u),       lk, 32'(e_locked[u]));
    chk($sformatf("u%0d.lockout_left", u), ll, 32'(e_left[u]));
  endtask

  task automatic check_all();
    check_unit(0, 32'(if0.collision_level), 32'(if0.collision_pulse), 32'(if0.frame_hits),
               32'(if0.hit_count), 32'(if0.locked), 32'(if0.lockout_left));
    check_unit(1, 32'(if1.collision_level), 32'(if1.collision_pulse), 32'(if1.frame_hits),
               32'(if1.hit_count), 32'(if1.locked), 32'(if1.lockout_left));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, sof, en, dr);
    model_step(1, sof, en, dr);
    #1;
    check_all();
  endtask

  // Reset pulse between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst.u1.locked", 32'(if1.locked), 32'd0);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [NO-1:0] pat [5];
    int k;
    k = 0;
    for (int i = 0; i < NO; i++)
      for (int j = i + 1; j < NO; j++) begin
        pi_a[k] = i; pj_a[k] = j; k++;
      end
    pm[0] = PM0; lm[0] = LM0; lf[0] = 60; cmax[0] = 255;
    pm[1] = PM1; lm[1] = LM1; lf[1] = 3;  cmax[1] = 3;
    pat[0] = 6'b000110; pat[1] = 6'b001010; pat[2] = 6'b010010;
    pat[3] = 6'b001100; pat[4] = 6'b010100;
    model_reset();

    // Reset state
    #1 check_all();
    @(negedge clk) reset = 1'b0;

    // Arm and open a frame
    en = 1'b1; tick();
    sof = 1'b1; tick(); sof = 1'b0;

    // Objects 0 and 1 overlap for five cycles: level every cycle, pulse once
    dr = 6'b000011;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ov.level0", 32'(if0.collision_level), 32'h0001);
      chk("ov.pulse0", 32'(if0.collision_pulse), (c == 0) ? 32'h0001 : 32'h0000);
    end
    chk("lk.entry.locked", 32'(if1.locked), 32'd1);
    chk("lk.entry.left", 32'(if1.lockout_left), 32'd3);
    dr = '0; tick();
    chk("ov.level_off", 32'(if0.collision_level), 32'h0000);
    sof = 1'b1; tick(); sof = 1'b0;
    chk("ov.frame_hits", 32'(if0.frame_hits), 32'h0001);
    chk("ov.hit_count", 32'(if0.hit_count), 32'd1);

    // Objects 0,1,2 on one pixel: pairs 0,1 and 5 pulse together
    dr = 6'b000111; tick();
    chk("sim.pulse.u0", 32'(if0.collision_pulse), 32'h0023);
    chk("sim.pulse.u1", 32'(if1.collision_pulse), 32'h0022);
    dr = '0; tick();
    sof = 1'b1; tick(); sof = 1'b0;
    chk("sim.hit_count.u0", 32'(if0.hit_count), 32'd3);
    chk("sim.hit_count.u1", 32'(if1.hit_count), 32'd2);

    // Mid-run reset discards partial state
    do_reset();

    // Lockout: three frames of suppressed pair-0 hits, then a pulse again
    tick();
    sof = 1'b1; tick(); sof = 1'b0;
    dr = 6'b000011; tick(); dr = '0;
    chk("lk.first.pulse0", 32'(if1.collision_pulse[0]), 32'd1);
    chk("lk.first.locked", 32'(if1.locked), 32'd1);
    chk("lk.first.left", 32'(if1.lockout_left), 32'd3);
    tick();
    for (int f = 1; f <= 3; f++) begin
      sof = 1'b1; tick(); sof = 1'b0;
      chk("lk.sof.locked", 32'(if1.locked), (f < 3) ? 32'd1 : 32'd0);
      chk("lk.sof.left", 32'(if1.lockout_left), 32'(3 - f));
      dr = 6'b000011; tick(); dr = '0;
      chk("lk.hit.pulse0", 32'(if1.collision_pulse[0]), (f == 3) ? 32'd1 : 32'd0);
      tick();
    end

    // Hit on the startOfFrame edge counts in the new frame
    dr = 6'b000011; sof = 1'b1; tick(); sof = 1'b0; dr = '0;
    chk("edge.pulse0", 32'(if0.collision_pulse), 32'h0001);
    chk("edge.old_frame", 32'(if0.frame_hits), 32'h0001);
    tick();
    sof = 1'b1; tick(); sof = 1'b0;
    chk("edge.new_frame", 32'(if0.frame_hits), 32'h0001);
    chk("edge.new_count", 32'(if0.hit_count), 32'd1);

    // Five pulses in one frame: 8-bit counter exact, 2-bit counter saturates
    for (int p = 0; p < 5; p++) begin
      dr = pat[p]; tick();
    end
    dr = '0; tick();
    sof = 1'b1; tick(); sof = 1'b0;
    chk("sat.u0", 32'(if0.hit_count), 32'd5);
    chk("sat.u1", 32'(if1.hit_count), 32'd3);

    // Masked pairs never report
    dr = 6'b110000; tick();
    chk("mask.u0.level", 32'(if0.collision_level), 32'h0000);
    chk("mask.u0.pulse", 32'(if0.collision_pulse), 32'h0000);
    chk("mask.u1.level", 32'(if1.collision_level), 32'h4000);
    dr = 6'b001001; tick();
    chk("mask.u1.level03", 32'(if1.collision_level), 32'h0000);
    chk("mask.u0.level03", 32'(if0.collision_level), 32'h0004);
    dr = '0; tick();

    // Disable during lockout
    sof = 1'b1; tick(); tick(); tick(); sof = 1'b0;
    dr = 6'b000011; tick();
    chk("dis.pre.locked", 32'(if1.locked), 32'd1);
    chk("dis.pre.left", 32'(if1.lockout_left), 32'd3);
    en = 1'b0; tick();
    chk("dis.locked", 32'(if1.locked), 32'd0);
    chk("dis.left", 32'(if1.lockout_left), 32'd0);
    chk("dis.pulse", 32'(if1.collision_pulse), 32'h0000);
    chk("dis.level", 32'(if1.collision_level), 32'h0001);
    tick();
    chk("dis.u0.pulse", 32'(if0.collision_pulse), 32'h0000);
    chk("dis.u0.level", 32'(if0.collision_level), 32'h0001);
    dr = '0; en = 1'b1; tick();

    // Random traffic against the reference model
    for (int r = 0; r < 3000; r++) begin
      sof = ($urandom_range(0, 5) == 0);
      en  = ($urandom_range(0, 19) != 0);
      dr  = 6'($urandom_range(0, 63));
      tick();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
